// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only link between flash_sample_reader and the flash controller.
//   master : flash_read, flash_address out; flash_waitrequest, flash_readdata,
//            flash_readdatavalid in
//   slave  : mirror image of master
interface flash_sample_reader_if #(
  parameter int unsigned ADDR_W = 23
) ();
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic [31:0]       flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Streams 8-bit speech samples out of flash, one per sample tick. Each 32-bit word
// holds four samples, played LSB byte first, over the word range start_addr..end_addr.
//   clk, reset_n          : clock, asynchronous active-low reset
//   play, stop            : phrase start (ignored while busy) / abort request
//   start_addr, end_addr  : inclusive word range, captured on accepted play
//   sample_tick           : one-cycle sample-rate strobe, already in clk domain
//   flash                 : Avalon-MM read master (one read outstanding at most)
//   audio_sample          : current sample, held between strobes
//   sample_strobe         : one-cycle pulse when audio_sample updates
//   busy, done, underrun  : phrase active / end-of-phrase pulse / sticky lost tick
module flash_sample_reader #(
  parameter int unsigned ADDR_W = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic                  sample_tick,
  flash_sample_reader_if.master flash,
  output logic [7:0]            audio_sample,
  output logic                  sample_strobe,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitData,
    StWaitTick,
    StEmit,
    StFinish
  } state_e;

  state_e            state_q;
  logic              flash_read_q;
  logic [ADDR_W-1:0] flash_address_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic [31:0]       word_q;
  logic [1:0]        k_q;
  logic              tick_pending_q;
  logic              abort_q;
  logic [7:0]        audio_sample_q;
  logic              sample_strobe_q;
  logic              busy_q;
  logic              done_q;
  logic              underrun_q;
  logic [7:0]        sel_byte;

  always_comb begin
    sel_byte = word_q[7:0];
    unique case (k_q)
      2'd0: sel_byte = word_q[7:0];
      2'd1: sel_byte = word_q[15:8];
      2'd2: sel_byte = word_q[23:16];
      2'd3: sel_byte = word_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      flash_read_q    <= 1'b0;
      flash_address_q <= '0;
      end_addr_q      <= '0;
      word_q          <= '0;
      k_q             <= 2'd0;
      tick_pending_q  <= 1'b0;
      abort_q         <= 1'b0;
      audio_sample_q  <= 8'h00;
      sample_strobe_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      sample_strobe_q <= 1'b0;
      done_q          <= 1'b0;

      // Ticks that cannot be consumed this cycle are banked; a second one is lost.
      if (sample_tick && (state_q inside {StReq, StWaitData, StEmit, StFinish})) begin
        if (tick_pending_q) underrun_q     <= 1'b1;
        else                tick_pending_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (play) begin
            end_addr_q <= end_addr;
            underrun_q <= 1'b0;
            busy_q     <= 1'b1;
            abort_q    <= 1'b0;
            if (start_addr > end_addr) begin
              state_q <= StFinish;
            end else begin
              flash_address_q <= start_addr;
              k_q             <= 2'd0;
              flash_read_q    <= 1'b1;
              state_q         <= StReq;
            end
          end
        end
        StReq: begin
          if (stop) abort_q <= 1'b1;
          if (!flash.flash_waitrequest) begin
            flash_read_q <= 1'b0;
            state_q      <= StWaitData;
          end
        end
        StWaitData: begin
          if (flash.flash_readdatavalid) begin
            // An aborted read still has to drain; its data is dropped.
            if (abort_q || stop) begin
              state_q <= StFinish;
            end else begin
              word_q  <= flash.flash_readdata;
              state_q <= StWaitTick;
            end
          end else if (stop) begin
            abort_q <= 1'b1;
          end
        end
        StWaitTick: begin
          if (stop) begin
            state_q <= StFinish;
          end else if (tick_pending_q || sample_tick) begin
            // Output is registered here so the sample lands one cycle after the tick.
            audio_sample_q  <= sel_byte;
            sample_strobe_q <= 1'b1;
            tick_pending_q  <= tick_pending_q && sample_tick;
            state_q         <= StEmit;
          end
        end
        StEmit: begin
          if (k_q != 2'd3) begin
            k_q     <= k_q + 2'd1;
            state_q <= StWaitTick;
          end else if (flash_address_q == end_addr_q) begin
            state_q <= StFinish;
          end else begin
            flash_address_q <= flash_address_q + 1'b1;
            k_q             <= 2'd0;
            flash_read_q    <= 1'b1;
            state_q         <= StReq;
          end
        end
        StFinish: begin
          done_q         <= 1'b1;
          busy_q         <= 1'b0;
          tick_pending_q <= 1'b0;
          abort_q        <= 1'b0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign flash.flash_read    = flash_read_q;
  assign flash.flash_address = flash_address_q;
  assign audio_sample        = audio_sample_q;
  assign sample_strobe       = sample_strobe_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign underrun            = underrun_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with an Avalon flash responder and tick source.
module tb_flash_sample_reader;
  localparam int unsigned ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              sample_tick;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [7:0]        audio_sample;
  logic              sample_strobe, busy, done, underrun;

  flash_sample_reader_if #(.ADDR_W(ADDR_W)) fif ();

  flash_sample_reader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play         (play),
    .stop         (stop),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .sample_tick  (sample_tick),
    .flash        (fif.master),
    .audio_sample (audio_sample),
    .sample_strobe(sample_strobe),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Knobs written only by the stimulus block.
  int unsigned wait_n = 0;
  int unsigned lat_n = 2;
  int unsigned tick_period = 0;
  logic [31:0] mem [int unsigned];

  // Responder / monitor state, written only by the always block below.
  int unsigned cyc = 0, last_tick_cyc = 0, n_acc = 0, n_done = 0, n_unstable = 0;
  int unsigned stall_cnt = 0, rsp_cnt = 0, tick_cnt = 0;
  bit          rsp_pend = 0, stalled = 0, valid_next;
  logic [31:0] data_next;
  logic [ADDR_W-1:0] stall_addr, rsp_addr;
  logic [7:0]        samples[$];
  int unsigned       deltas[$];
  logic [ADDR_W-1:0] acc_addr[$];

  always @(posedge clk) begin
    cyc++;
    if (sample_strobe) begin
      samples.push_back(audio_sample);
      deltas.push_back(cyc - last_tick_cyc);
    end
    if (sample_tick) last_tick_cyc = cyc;
    if (done) n_done++;
    if (fif.flash_read && stalled && fif.flash_address != stall_addr) n_unstable++;
    stalled    = fif.flash_read && fif.flash_waitrequest;
    stall_addr = fif.flash_address;
    valid_next = 0;
    data_next  = 32'hDEAD_BEEF;
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        valid_next = 1;
        rsp_pend   = 0;
        data_next  = mem.exists(32'(rsp_addr)) ? mem[32'(rsp_addr)] : 32'h0;
      end else begin
        rsp_cnt--;
      end
    end
    if (fif.flash_read && !fif.flash_waitrequest) begin
      n_acc++;
      acc_addr.push_back(fif.flash_address);
      rsp_addr = fif.flash_address;
      rsp_pend = 1;
      rsp_cnt  = lat_n - 2;
    end
    #1;
    fif.flash_readdatavalid = valid_next;
    fif.flash_readdata      = data_next;
    if (fif.flash_read && stall_cnt < wait_n) begin
      fif.flash_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      fif.flash_waitrequest = 1'b0;
      stall_cnt = 0;
    end
    if (tick_period != 0 && tick_cnt + 1 >= tick_period) begin
      sample_tick = 1'b1;
      tick_cnt    = 0;
    end else begin
      sample_tick = 1'b0;
      if (tick_period != 0) tick_cnt++;
    end
  end

  int unsigned n_vec = 0, n_err = 0;
  int unsigned play_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    start_addr = s;
    end_addr   = e;
    play       = 1'b1;
    play_cyc   = cyc;
    step(1);
    play       = 1'b0;
  endtask

  // Returns the offset of the done pulse from the play cycle.
  task automatic wait_done(input string tag, input int unsigned bound, output int unsigned dt);
    bit got = 0;
    for (int i = 0; i < int'(bound); i++) begin
      if (done) begin
        got = 1;
        break;
      end
      step(1);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    dt = cyc - play_cyc;
  endtask

  initial begin : stim
    int unsigned bs, ba, bd, dt;

    // Reset values, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("rst_read", 32'(fif.flash_read), 32'd0);
    check("rst_addr", 32'(fif.flash_address), 32'd0);
    check("rst_audio", 32'(audio_sample), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    step(4);
    reset_n = 1'b1;
    step(2);

    // Single word at 0x10.
    mem[32'h10] = 32'hBC80_7F01;
    tick_period = 2272;
    bs = samples.size(); ba = n_acc; bd = n_done;
    do_play(23'h10, 23'h10);
    check("t1_busy_n1", 32'(busy), 32'd1);
    check("t1_read_n1", 32'(fif.flash_read), 32'd1);
    check("t1_addr_n1", 32'(fif.flash_address), 32'h10);
    wait_done("t1", 6 * 2272 + 500, dt);
    check("t1_nsamples", samples.size() - bs, 32'd4);
    check("t1_s0", 32'(samples[bs + 0]), 32'h01);
    check("t1_s1", 32'(samples[bs + 1]), 32'h7F);
    check("t1_s2", 32'(samples[bs + 2]), 32'h80);
    check("t1_s3", 32'(samples[bs + 3]), 32'hBC);
    check("t1_tick_to_strobe", deltas[bs + 1], 32'd1);
    check("t1_nreads", n_acc - ba, 32'd1);
    check("t1_read_addr", 32'(acc_addr[ba]), 32'h10);
    check("t1_underrun", 32'(underrun), 32'd0);
    step(1);
    check("t1_ndone", n_done - bd, 32'd1);

    // Three words with 5-cycle waitrequest stalls.
    mem[32'h20] = 32'h0403_0201;
    mem[32'h21] = 32'h0807_0605;
    mem[32'h22] = 32'h0C0B_0A09;
    wait_n = 5;
    tick_period = 40;
    step(50);
    bs = samples.size(); ba = n_acc;
    do_play(23'h20, 23'h22);
    wait_done("t2", 16 * 40 + 200, dt);
    check("t2_nsamples", samples.size() - bs, 32'd12);
    for (int i = 0; i < 12; i++) check("t2_sample", 32'(samples[bs + i]), 32'(i + 1));
    check("t2_nreads", n_acc - ba, 32'd3);
    check("t2_addr0", 32'(acc_addr[ba + 0]), 32'h20);
    check("t2_addr1", 32'(acc_addr[ba + 1]), 32'h21);
    check("t2_addr2", 32'(acc_addr[ba + 2]), 32'h22);
    check("t2_addr_stable", n_unstable, 32'd0);
    check("t2_underrun", 32'(underrun), 32'd0);

    // Empty range: no flash access, done two cycles after play.
    wait_n = 0;
    tick_period = 0;
    step(3);
    bs = samples.size(); ba = n_acc;
    do_play(23'h31, 23'h30);
    check("t3_busy_n1", 32'(busy), 32'd1);
    check("t3_read_n1", 32'(fif.flash_read), 32'd0);
    wait_done("t3", 20, dt);
    check("t3_done_delay", dt, 32'd2);
    step(3);
    check("t3_nreads", n_acc - ba, 32'd0);
    check("t3_nsamples", samples.size() - bs, 32'd0);

    // Overrun: data arrives after two ticks have been missed.
    mem[32'h40] = 32'h4443_4241;
    lat_n = 5000;
    tick_period = 2272;
    bs = samples.size();
    do_play(23'h40, 23'h40);
    wait_done("t4", 5000 + 6 * 2272 + 500, dt);
    check("t4_nsamples", samples.size() - bs, 32'd4);
    for (int i = 0; i < 4; i++) check("t4_sample", 32'(samples[bs + i]), 32'(8'h41 + i));
    step(5);
    check("t4_underrun_held", 32'(underrun), 32'd1);
    do_play(23'h31, 23'h30);
    check("t4_underrun_cleared", 32'(underrun), 32'd0);
    wait_done("t4b", 20, dt);

    // Stop while the read is outstanding: drain, discard, finish.
    mem[32'h50] = 32'h5453_5251;
    lat_n = 20;
    tick_period = 0;
    step(3);
    bs = samples.size(); ba = n_acc;
    do_play(23'h50, 23'h50);
    step(2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_done("t5", 100, dt);
    check("t5_done_delay", dt, 32'd23);
    step(30);
    check("t5_nreads", n_acc - ba, 32'd1);
    check("t5_read_idle", 32'(fif.flash_read), 32'd0);
    check("t5_nsamples", samples.size() - bs, 32'd0);

    // Asynchronous reset while stalled in REQ, then a clean restart.
    wait_n = 1000;
    lat_n = 2;
    do_play(23'h60, 23'h60);
    step(3);
    check("t6_read_before_rst", 32'(fif.flash_read), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_read", 32'(fif.flash_read), 32'd0);
    check("t6_rst_addr", 32'(fif.flash_address), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_audio", 32'(audio_sample), 32'd0);
    step(3);
    reset_n = 1'b1;
    wait_n = 0;
    tick_period = 40;
    mem[32'h60] = 32'h6463_6261;
    step(3);
    bs = samples.size(); ba = n_acc;
    do_play(23'h60, 23'h60);
    wait_done("t6", 6 * 40 + 200, dt);
    check("t6_nreads", n_acc - ba, 32'd1);
    check("t6_read_addr", 32'(acc_addr[ba]), 32'h60);
    check("t6_nsamples", samples.size() - bs, 32'd4);
    for (int i = 0; i < 4; i++) check("t6_sample", 32'(samples[bs + i]), 32'(8'h61 + i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
# flash_sample_reader

Fetches 8-bit speech samples from on-board flash over an Avalon-MM read master and presents them one per sample tick to the audio path (codec output and the LED level meter). Each 32-bit flash word carries four samples, played least-significant byte first. A `play` pulse runs a phrase from `start_addr` to `end_addr` inclusive. `sample_strobe` is the meter's `start` input and `audio_sample` is its `audio_signal` input.

## Interface
- ADDR_W, 23, flash word-address width
- clk  in  1  system clock (50 MHz); all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- play  in  1  one-cycle request to start a phrase; ignored while busy
- stop  in  1  one-cycle abort request
- start_addr  in  ADDR_W  first word address, sampled on accepted play
- end_addr  in  ADDR_W  last word address (inclusive), sampled on accepted play
- sample_tick  in  1  one-cycle strobe at sample rate (22 kHz), already synchronised to clk
- flash_read  out  1  Avalon read request
- flash_address  out  ADDR_W  Avalon word address
- flash_waitrequest  in  1  Avalon stall
- flash_readdata  in  32  Avalon read data
- flash_readdatavalid  in  1  Avalon data valid
- audio_sample  out  8  current sample, raw two's-complement byte, held between strobes
- sample_strobe  out  1  one-cycle pulse when audio_sample updates
- busy  out  1  high from accepted play until done pulse
- done  out  1  one-cycle pulse at end or abort of phrase
- underrun  out  1  sticky: a tick was lost; cleared on accepted play

## Operation
- States: IDLE, REQ, WAIT_DATA, WAIT_TICK, EMIT, FINISH.
- IDLE: on play, latch addresses, clear underrun, set busy. If start_addr > end_addr, go to FINISH with no flash access. Otherwise set flash_address = start_addr, byte index k = 0, go to REQ.
- REQ: flash_read = 1 and flash_address stable until a cycle with flash_waitrequest = 0. Then deassert flash_read, go to WAIT_DATA.
- WAIT_DATA: on flash_readdatavalid, latch the word, go to WAIT_TICK. Exactly one read is outstanding at a time.
- WAIT_TICK: if tick_pending, or sample_tick this cycle, go to EMIT and consume the tick.
- EMIT: audio_sample = word byte k (k=0 is bits 7:0, k=3 is bits 31:24). Pulse sample_strobe.
  - k < 3: k+1, go to WAIT_TICK.
  - k = 3 and address = end_addr: go to FINISH.
  - Otherwise: address+1, k=0, go to REQ.
- FINISH: pulse done, clear busy and tick_pending, go to IDLE.
- Tick capture: a sample_tick in REQ, WAIT_DATA, EMIT or FINISH sets tick_pending. A tick arriving while tick_pending is already set (and not consumed that cycle) is dropped and sets underrun. Ticks in IDLE are ignored.
- stop:
  - In WAIT_TICK: go to FINISH immediately.
  - In REQ or WAIT_DATA: latch an abort flag, complete the current transaction (wait for readdatavalid, discard the word), then go to FINISH. This is required; the outstanding read may not be abandoned.
  - stop in IDLE has no effect.
  - stop and play in the same IDLE cycle: play wins.
- Address arithmetic is ADDR_W-bit unsigned. The end comparison uses equality, so wrap-around never occurs within a valid range.

## Timing
- Reset values: flash_read 0, flash_address 0, audio_sample 8'h00, sample_strobe 0, busy 0, done 0, underrun 0, state IDLE, tick_pending 0.
- All outputs are registered.
- play at cycle n: busy = 1 and flash_read = 1 at n+1.
- With zero waitrequest and readdatavalid two cycles after acceptance, the first word is latched 4 cycles after play.
- A tick consumed in WAIT_TICK at cycle m gives audio_sample/sample_strobe at m+1.
- Word fetch overlaps the gap after the 4th sample. Fetch latency must stay below one tick period (2272 clk) to avoid underrun.
- done rises the cycle after FINISH is entered; busy falls in the same cycle as done.

## Test plan
- Single word: start=end=0x10, word 0xBC80_7F01, ticks every 2272 cycles → audio_sample 0x01, 0x7F, 0x80, 0xBC on four strobes; then done; exactly one flash_read transaction.
- Three words 0x20..0x22 with waitrequest held 5 cycles per read → addresses 0x20, 0x21, 0x22 in order; 12 strobes; flash_address stable while waitrequest is high; underrun stays 0.
- Empty range: start=0x31, end=0x30 → done 2 cycles after play; flash_read never asserted; no strobe.
- Overrun: readdatavalid delayed 5000 cycles with ticks every 2272 → underrun = 1 and held; samples still emitted in order; next play clears underrun.
- stop during WAIT_DATA → flash_read not reissued; word discarded with no strobe; done one cycle after FINISH; busy = 0.
- reset_n low mid-phrase (in REQ) → all outputs return to reset values asynchronously; after release, a new play starts cleanly from start_addr.
